// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the ALU execution unit.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_SHL  = 4'h4,
    OP_SHR  = 4'h5,
    OP_ROL  = 4'h6,
    OP_ROR  = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'hA,
    OP_NOR  = 4'hB,
    OP_NAND = 4'hC,
    OP_XNOR = 4'hD,
    OP_GT   = 4'hE,
    OP_EQ   = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic logic is_iter(input alu_op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_exec_unit_muldiv.sv
// WIDTH-step shift-add multiplier and restoring divider sharing one {hi,lo} register pair.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             active_q, active_d;
  logic             is_div_q, is_div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] fin_hi, fin_lo;
  logic             div_zero;

  // MUL: hi accumulates, lo holds the shifting multiplier. DIV: hi is the
  // partial remainder, lo shifts the dividend out and the quotient in.
  always_comb begin
    addend = lo_q[0] ? opd_q : '0;
    sum    = {1'b0, hi_q} + {1'b0, addend};
    rem_sh = {hi_q, lo_q[WIDTH-1]};
    ge     = rem_sh >= {1'b0, opd_q};
    if (is_div_q) begin
      step_hi = ge ? (rem_sh[WIDTH-1:0] - opd_q) : rem_sh[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // On the final step the result is presented combinationally so the
  // caller can write it on the same edge; afterwards it is held in hi/lo.
  always_comb begin
    done     = active_q && (cnt_q == LAST);
    fin_hi   = done ? step_hi : hi_q;
    fin_lo   = done ? step_lo : lo_q;
    div_zero = is_div_q && (opd_q == '0);
    if (div_zero) begin
      result = '1;
      flag   = 1'b1;
    end else begin
      result = fin_lo;
      flag   = is_div_q ? 1'b0 : (|fin_hi);
    end
  end

  always_comb begin
    active_d = active_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    opd_d    = opd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (start) begin
      active_d = 1'b1;
      is_div_d = (op == OP_DIV);
      opd_d    = (op == OP_DIV) ? b : a;
      hi_d     = '0;
      lo_d     = (op == OP_DIV) ? a : b;
      cnt_d    = '0;
    end else if (active_q) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + 1'b1;
      if (done) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      opd_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      active_q <= active_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      opd_q    <= opd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU responder: single-cycle ops land in the output slot on accept,
// MUL/DIV run through the iterative unit and land when the slot is free.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             carry_q, carry_d;

  alu_op_e          op;
  logic             slot_free;
  logic             accept;
  logic             start;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic             md_flag;

  assign op        = alu_op_e'(ALU_Sel);
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == IDLE) && slot_free;
  assign accept    = in_valid && in_ready;
  assign start     = accept && is_iter(op);

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    case (op)
      OP_ADD:  {sc_carry, sc_res} = {1'b0, A} + {1'b0, B};
      OP_SUB: begin
        sc_res   = A - B;
        sc_carry = A < B;
      end
      OP_SHL: begin
        sc_res   = {A[WIDTH-2:0], 1'b0};
        sc_carry = A[WIDTH-1];
      end
      OP_SHR: begin
        sc_res   = {1'b0, A[WIDTH-1:1]};
        sc_carry = A[0];
      end
      OP_ROL:  sc_res = {A[WIDTH-2:0], A[WIDTH-1]};
      OP_ROR:  sc_res = {A[0], A[WIDTH-1:1]};
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      OP_NOR:  sc_res = ~(A | B);
      OP_NAND: sc_res = ~(A & B);
      OP_XNOR: sc_res = ~(A ^ B);
      OP_GT:   sc_res = {{(WIDTH-1){1'b0}}, (A > B)};
      OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (A == B)};
      default: begin
        sc_res   = '0;
        sc_carry = 1'b0;
      end
    endcase
  end

  alu_iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (A),
    .b      (B),
    .done   (md_done),
    .result (md_result),
    .flag   (md_flag)
  );

  // A consumed slot empties unless it is refilled on the same edge.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    alu_out_d   = alu_out_q;
    carry_d     = carry_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_iter(op)) begin
            state_d = ITER;
          end else begin
            out_valid_d = 1'b1;
            alu_out_d   = sc_res;
            carry_d     = sc_carry;
          end
        end
      end
      ITER: begin
        if (md_done) begin
          if (slot_free) begin
            out_valid_d = 1'b1;
            alu_out_d   = md_result;
            carry_d     = md_flag;
            state_d     = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          alu_out_d   = md_result;
          carry_d     = md_flag;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      carry_q     <= carry_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ALU_Out   = alu_out_q;
  assign CarryOut  = carry_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors plus randomized ops against an arithmetic model.
module tb_alu_exec_unit;

  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [3:0]    ALU_Sel = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  ALU_Out;
  logic          CarryOut;
  logic          busy;

  typedef struct {
    logic [15:0] r;
    logic        c;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   or_mode = 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_Out   (ALU_Out),
    .CarryOut  (CarryOut),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic c);
    int unsigned ua, ub, t;
    ua = a;
    ub = b;
    t  = 0;
    c  = 1'b0;
    case (op)
      4'h0: begin t = ua + ub; c = t[16]; end
      4'h1: begin t = ua - ub; c = (ua < ub); end
      4'h2: begin t = ua * ub; c = ((t >> 16) != 0); end
      4'h3: begin
        if (ub == 0) begin t = 32'hFFFF; c = 1'b1; end
        else t = ua / ub;
      end
      4'h4: begin t = ua * 2; c = t[16]; end
      4'h5: begin t = ua / 2; c = (ua % 2) != 0; end
      4'h6: t = ua * 2 + ua / 32768;
      4'h7: t = ua / 2 + (ua % 2) * 32768;
      4'h8: t = ua & ub;
      4'h9: t = ua | ub;
      4'hA: t = ua ^ ub;
      4'hB: t = ~(ua | ub);
      4'hC: t = ~(ua & ub);
      4'hD: t = ~(ua ^ ub);
      4'hE: t = (ua > ub) ? 1 : 0;
      default: t = (ua == ub) ? 1 : 0;
    endcase
    r = t[15:0];
  endfunction

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] er, input logic ec, input int lat);
    int   n;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    ALU_Sel  = op;
    A        = a;
    B        = b;
    #3;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept op=%h", op);
      in_valid = 1'b0;
    end else begin
      e.r   = er;
      e.c   = ec;
      e.lat = lat;
      e.cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic send_rand(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        c;
    model(op, a, b, r, c);
    send(op, a, b, r, c, -1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("drain_scoreboard", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: drives out_ready, compares the presented result with the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      case (or_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      #3;
      if (!reset && out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h/%b required=none", ALU_Out, CarryOut);
        end else begin
          e = sb[0];
          if (out_ready) begin
            check("result_data", 32'(ALU_Out), 32'(e.r));
            check("result_carry", 32'(CarryOut), 32'(e.c));
            if (e.lat >= 0) check("latency", cyc - e.cyc - 1, e.lat);
            void'(sb.pop_front());
          end else begin
            check("held_data", 32'(ALU_Out), 32'(e.r));
            check("held_carry", 32'(CarryOut), 32'(e.c));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] a, b;
    int          c0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu_out", 32'(ALU_Out), 32'd0);
    check("rst_carry", 32'(CarryOut), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single-cycle ops on A=00FA, B=0002, plus edge cases.
    or_mode = 1;
    send(4'h0, 16'h00FA, 16'h0002, 16'h00FC, 1'b0, 0);
    send(4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 0);
    send(4'h1, 16'h0002, 16'h00FA, 16'hFF08, 1'b1, 0);
    send(4'h4, 16'h00FA, 16'h0002, 16'h01F4, 1'b0, 0);
    send(4'h5, 16'h00FA, 16'h0002, 16'h007D, 1'b0, 0);
    send(4'h6, 16'h00FA, 16'h0002, 16'h01F4, 1'b0, 0);
    send(4'h7, 16'h00FA, 16'h0002, 16'h007D, 1'b0, 0);
    send(4'h8, 16'h00FA, 16'h0002, 16'h0002, 1'b0, 0);
    send(4'h9, 16'h00FA, 16'h0002, 16'h00FA, 1'b0, 0);
    send(4'hA, 16'h00FA, 16'h0002, 16'h00F8, 1'b0, 0);
    send(4'hB, 16'h00FA, 16'h0002, 16'hFF05, 1'b0, 0);
    send(4'hC, 16'h00FA, 16'h0002, 16'hFFFD, 1'b0, 0);
    send(4'hD, 16'h00FA, 16'h0002, 16'hFF07, 1'b0, 0);
    send(4'hE, 16'h00FA, 16'h0002, 16'h0001, 1'b0, 0);
    send(4'hF, 16'h00FA, 16'h0002, 16'h0000, 1'b0, 0);
    send(4'h4, 16'h8001, 16'h0000, 16'h0002, 1'b1, 0);
    send(4'h7, 16'h0001, 16'h0000, 16'h8000, 1'b0, 0);
    idle();
    wait_empty();

    // MUL: busy and in_ready held through all 16 iteration cycles.
    send(4'h2, 16'h00FA, 16'h0002, 16'h01F4, 1'b0, 16);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) in_valid = 1'b0;
      #3;
      check("mul_busy", 32'(busy), 32'd1);
      check("mul_in_ready", 32'(in_ready), 32'd0);
    end
    wait_empty();
    send(4'h2, 16'h0100, 16'h0100, 16'h0000, 1'b1, 16);
    send(4'h3, 16'h00FA, 16'h0002, 16'h007D, 1'b0, 16);
    send(4'h3, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 16);
    send(4'h3, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 16);
    idle();
    wait_empty();

    // Backpressure on a single-cycle result.
    or_mode = 2;
    send(4'h0, 16'h1234, 16'h1111, 16'h2345, 1'b0, -1);
    idle();
    repeat (5) begin
      @(negedge clk);
      #3;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    or_mode = 1;
    wait_empty();

    // MUL completing while the consumer stalls.
    or_mode = 2;
    send(4'h2, 16'h0003, 16'h0005, 16'h000F, 1'b0, -1);
    idle();
    repeat (25) @(negedge clk);
    #3;
    check("bp_mul_valid", 32'(out_valid), 32'd1);
    check("bp_mul_in_ready", 32'(in_ready), 32'd0);
    or_mode = 1;
    wait_empty();

    // Stream of 8 ADDs, one accept per cycle.
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] r;
      logic        c;
      a = 16'($urandom);
      b = 16'($urandom);
      model(4'h0, a, b, r, c);
      send(4'h0, a, b, r, c, 0);
    end
    check("stream_cycles", cyc - c0, 8);
    idle();
    wait_empty();

    // Reset while the MUL counter sits at 7.
    send(4'h2, 16'h00FA, 16'h0002, 16'h01F4, 1'b0, 16);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
    end
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    #3;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    send(4'h0, 16'h00FA, 16'h0002, 16'h00FC, 1'b0, 0);
    idle();
    wait_empty();

    // Randomized mix with random backpressure and request gaps.
    or_mode = 0;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'h0000;
        1:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) idle();
      send_rand(op, a, b);
    end
    idle();
    or_mode = 1;
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
